hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Registered forwarding and load-use hazard controller for the five-stage MIPS pipeline. It tracks the destination register, write-enable and load flag of the instructions in EX, MEM and WB in an internal shadow pipeline. From these it drives the 2-bit select codes of the two ALU-operand `mux4to1` instances (one per operand) in the EX stage. It also raises the stall request for the PC and IF/ID latches on a load-use hazard, and counts stall cycles for the debug unit.

## Interface
- `NB_REG`, 5: register-address width.
- `NB_CNT`, 16: stall-counter width.
- `i_clk`  in  1  pipeline clock; all state updates on rising edge.
- `i_rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `i_halt`  in  1  debug freeze; all state holds.
- `i_flush`  in  1  branch/jump taken; squash instructions in ID and EX.
- `i_id_valid`  in  1  ID holds a real instruction.
- `i_id_rs`  in  NB_REG  source register A of the ID instruction.
- `i_id_rt`  in  NB_REG  source register B of the ID instruction.
- `i_id_use_rs`  in  1  ID instruction reads rs.
- `i_id_use_rt`  in  1  ID instruction reads rt.
- `i_id_dest`  in  NB_REG  destination register of the ID instruction.
- `i_id_reg_write`  in  1  ID instruction writes the register file.
- `i_id_mem_read`  in  1  ID instruction is a load.
- `o_sel_a`  out  2  select code for the operand-A mux (EX stage).
- `o_sel_b`  out  2  select code for the operand-B mux (EX stage).
- `o_stall`  out  1  hold PC and IF/ID; insert a bubble into EX.
- `o_stall_count`  out  NB_CNT  saturating count of stall cycles.

## Operation
- Select codes:
  - 00 = register-file value (mux input A).
  - 01 = EX/MEM ALU result (mux input B).
  - 10 = MEM/WB write-back value (mux input C).
  - 11 is reserved and is never driven.
- Shadow slots EX, MEM and WB each hold {valid, dest, reg_write, mem_read}. On each advancing edge, ID goes to EX, EX to MEM, and MEM to WB.
- Forwarding decision, made at the edge that moves ID into EX. For each operand with use=1:
  - The current EX slot (becoming MEM) matches, with valid, reg_write and dest≠0 → 01.
  - Otherwise the current MEM slot (becoming WB) matches under the same conditions → 10.
  - Otherwise → 00.
  - EX/MEM has priority over MEM/WB.
  - Operand with use=0 → 00.
- Load-use hazard: `o_stall` is asserted combinationally when all of the following hold:
  - i_id_valid is 1.
  - The EX slot is valid with mem_read=1, reg_write=1 and dest≠0.
  - Dest equals a used rs or rt of the ID instruction.
- Event priority, per edge:
  - i_halt: nothing changes, including selects and counter; `o_stall` is still evaluated combinationally.
  - i_flush (no halt): EX slot ← bubble, MEM ← old EX, WB ← old MEM, selects ← 00. `o_stall` is forced to 0, and the counter does not increment.
  - o_stall (no halt, no flush): EX slot ← bubble, MEM ← old EX, WB ← old MEM, selects ← 00. The ID instruction is re-evaluated next cycle and then gets 10 for the loaded register. Counter increments, saturating at all-ones.
  - Otherwise: normal advance.
- A bubble is defined as valid=0 with all other slot fields cleared.
- The WB slot is tracked for completeness only; the register file writes in the first half-cycle, so a WB match yields 00.

## Timing
- Reset, while i_rst_n=0 (asynchronous):
  - All slots invalid.
  - o_sel_a = o_sel_b = 00.
  - o_stall = 0 (no valid EX slot).
  - o_stall_count = 0.
- Selects are registered. They are valid for the whole cycle in which the corresponding instruction occupies EX, a latency of 1 edge after ID evaluation.
- o_stall is combinational from the ID inputs and the EX slot, in the same cycle, with no register.
- A load followed immediately by a dependent instruction yields exactly one stall cycle. A dependency at distance 2 yields 00 select… corrected: distance 2 yields 10 with no stall, and distance 3 yields 00.
- Reset deasserted mid-stream: the first edge after release behaves as a normal advance from the all-bubble state.

## Structure
- Shared package `pipeline_pkg`:
  - Select encodings SEL_RF = 2'b00, SEL_EXMEM = 2'b01, SEL_MEMWB = 2'b10.
  - NB_REG.
  - The slot struct {valid, dest, reg_write, mem_read}.
- One sub-module, `fwd_match`: a combinational comparator that returns a 2-bit select for one operand against the EX and MEM slots. It is instantiated twice, once for rs and once for rt.

## Test plan
- Reset: assert i_rst_n=0 mid-run → all outputs 0 immediately, without waiting for a clock edge.
- ALU chain: `add $3,$1,$2` then `sub $4,$3,$5` → o_sel_a=01 and o_sel_b=00 during the sub's EX cycle; no stall.
- Distance 2: `add $3`, `nop`, then `or $6,$7,$3` → o_sel_b=10. For `$0` as dest in the same sequence → 00.
- Load-use: `lw $8` then `add $9,$8,$8` → o_stall=1 for exactly one cycle, then o_sel_a=o_sel_b=10, and o_stall_count increments by 1.
- Load-use with flush in the same cycle → o_stall=0, no count increment, and the EX slot becomes a bubble (next selects 00).
- Halt held for 5 cycles during a pending forward → selects and counter are frozen. After release, the sequence resumes with identical results, and the counter saturates at 0xFFFF under forced continuous stall.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: operand-mux select codes and the hazard shadow-slot record.
package pipeline_pkg;

  localparam int NB_REG = 5;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [NB_REG-1:0] dest;
    logic              reg_write;
    logic              mem_read;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/fwd_match.sv
// Per-operand forwarding comparator: picks the youngest in-flight writer of the source register.
module fwd_match
  import pipeline_pkg::*;
(
  input  logic              use_i,
  input  logic [NB_REG-1:0] src_i,
  input  logic [NB_REG-1:0] ex_dest_i,
  input  logic              ex_wr_i,
  input  logic [NB_REG-1:0] mem_dest_i,
  input  logic              mem_wr_i,
  output logic [1:0]        sel_o
);

  logic hit_ex;
  logic hit_mem;

  // $0 is hardwired to zero, so a write to it never produces a forwardable value
  assign hit_ex  = use_i && ex_wr_i  && (ex_dest_i  != '0) && (ex_dest_i  == src_i);
  assign hit_mem = use_i && mem_wr_i && (mem_dest_i != '0) && (mem_dest_i == src_i);

  always_comb begin
    sel_o = SEL_RF;
    if (hit_ex) begin
      sel_o = SEL_EXMEM;
    end else if (hit_mem) begin
      sel_o = SEL_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Registered ALU-operand forwarding selects and load-use stall request with a saturating stall counter.
module hazard_forward_unit #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_halt,
  input  logic              i_flush,
  input  logic              i_id_valid,
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic [NB_REG-1:0] i_id_dest,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  output logic [1:0]        o_sel_a,
  output logic [1:0]        o_sel_b,
  output logic              o_stall,
  output logic [NB_CNT-1:0] o_stall_count
);
  import pipeline_pkg::*;

  slot_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  slot_t             id_slot;
  logic [1:0]        sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [1:0]        fwd_a, fwd_b;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic              load_use;
  logic              unused_wb;

  always_comb begin
    id_slot = SLOT_BUBBLE;
    if (i_id_valid) begin
      id_slot.valid     = 1'b1;
      id_slot.dest      = i_id_dest;
      id_slot.reg_write = i_id_reg_write;
      id_slot.mem_read  = i_id_mem_read;
    end
  end

  assign load_use = i_id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
                    (ex_q.dest != '0) &&
                    ((i_id_use_rs && (i_id_rs == ex_q.dest)) ||
                     (i_id_use_rt && (i_id_rt == ex_q.dest)));

  // A taken branch squashes the ID instruction, so its hazard is moot
  assign o_stall = load_use && !i_flush;

  fwd_match u_fwd_a (
    .use_i      (i_id_valid && i_id_use_rs),
    .src_i      (i_id_rs),
    .ex_dest_i  (ex_q.dest),
    .ex_wr_i    (ex_q.valid && ex_q.reg_write),
    .mem_dest_i (mem_q.dest),
    .mem_wr_i   (mem_q.valid && mem_q.reg_write),
    .sel_o      (fwd_a)
  );

  fwd_match u_fwd_b (
    .use_i      (i_id_valid && i_id_use_rt),
    .src_i      (i_id_rt),
    .ex_dest_i  (ex_q.dest),
    .ex_wr_i    (ex_q.valid && ex_q.reg_write),
    .mem_dest_i (mem_q.dest),
    .mem_wr_i   (mem_q.valid && mem_q.reg_write),
    .sel_o      (fwd_b)
  );

  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    cnt_d   = cnt_q;
    if (!i_halt) begin
      mem_d = ex_q;
      wb_d  = mem_q;
      if (i_flush || load_use) begin
        ex_d    = SLOT_BUBBLE;
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
        if (!i_flush && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        ex_d    = id_slot;
        sel_a_d = fwd_a;
        sel_b_d = fwd_b;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q    <= SLOT_BUBBLE;
      mem_q   <= SLOT_BUBBLE;
      wb_q    <= SLOT_BUBBLE;
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // WB is kept only as a record; the register file already resolves that distance
  assign unused_wb = ^wb_q;

  assign o_sel_a       = sel_a_q;
  assign o_sel_b       = sel_b_q;
  assign o_stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: instruction-level pipeline model plus directed MIPS sequences.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       halt, flush;
  logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_dest;

  logic [1:0]  sel_a, sel_b, s_sel_a, s_sel_b;
  logic        stall, s_stall;
  logic [15:0] cnt;
  logic [3:0]  s_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.NB_REG(5), .NB_CNT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_halt(halt), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt), .i_id_dest(id_dest),
    .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read),
    .o_sel_a(sel_a), .o_sel_b(sel_b), .o_stall(stall), .o_stall_count(cnt)
  );

  // Narrow counter instance so saturation is reachable in a short run
  hazard_forward_unit #(.NB_REG(5), .NB_CNT(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_halt(halt), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt), .i_id_dest(id_dest),
    .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read),
    .o_sel_a(s_sel_a), .o_sel_b(s_sel_b), .o_stall(s_stall), .o_stall_count(s_cnt)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
  endtask

  // Model: list of in-flight instructions, index = distance past ID (0=EX, 1=MEM, 2=WB)
  typedef struct { bit v; int dest; bit rw; bit mr; } ins_t;
  ins_t pipe[3];
  int   m_sel_a, m_sel_b, n_stall;
  int   m_sa, m_sb;
  bit   m_lu;

  function automatic int fwd_sel(bit used, int src);
    if (!used || src == 0) return 0;
    for (int d = 0; d < 2; d++)
      if (pipe[d].v && pipe[d].rw && pipe[d].dest == src) return (d == 0) ? 1 : 2;
    return 0;
  endfunction

  function automatic bit load_use_m();
    if (!id_valid || !pipe[0].v || !pipe[0].mr || !pipe[0].rw || pipe[0].dest == 0) return 0;
    return (id_use_rs && int'(id_rs) == pipe[0].dest) || (id_use_rt && int'(id_rt) == pipe[0].dest);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
      m_sel_a = 0; m_sel_b = 0; n_stall = 0;
    end else if (!halt) begin
      m_sa = fwd_sel(id_valid && id_use_rs, int'(id_rs));
      m_sb = fwd_sel(id_valid && id_use_rt, int'(id_rt));
      m_lu = load_use_m();
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (flush || m_lu) begin
        pipe[0] = '{0, 0, 0, 0};
        m_sel_a = 0; m_sel_b = 0;
        if (!flush) n_stall++;
      end else begin
        pipe[0] = id_valid ? '{1, int'(id_dest), id_reg_write, id_mem_read} : '{0, 0, 0, 0};
        m_sel_a = m_sa; m_sel_b = m_sb;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("sel_a", sel_a, m_sel_a);
      chk("sel_b", sel_b, m_sel_b);
      chk("stall", stall, (load_use_m() && !flush) ? 1 : 0);
      chk("count", cnt, (n_stall > 65535) ? 65535 : n_stall);
      chk("count_sat", s_cnt, (n_stall > 15) ? 15 : n_stall);
    end
  end

  task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int dest, input bit rw, input bit mr);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_dest = 5'(dest); id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // lw $8 ; add $9,$8,$8 -> stall, then forward from MEM/WB; then async reset
    set_id(1, 1, 0, 1, 0, 8, 1, 1); tick();
    set_id(1, 8, 8, 1, 1, 9, 1, 0); #1 chk("pre_rst_stall", stall, 1);
    tick(); tick();
    chk("pre_rst_sel_a", sel_a, 2); chk("pre_rst_cnt", cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sel_a", sel_a, 0); chk("rst_sel_b", sel_b, 0);
    chk("rst_stall", stall, 0); chk("rst_cnt", cnt, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;

    // add $3,$1,$2 ; sub $4,$3,$5
    set_id(1, 1, 2, 1, 1, 3, 1, 0); tick();
    set_id(1, 3, 5, 1, 1, 4, 1, 0); #1 chk("chain_stall", stall, 0);
    tick();
    chk("chain_sel_a", sel_a, 1); chk("chain_sel_b", sel_b, 0);

    // add $3 ; nop ; or $6,$7,$3
    set_id(1, 1, 2, 1, 1, 3, 1, 0); tick();
    set_id(1, 0, 0, 0, 0, 0, 0, 0); tick();
    set_id(1, 7, 3, 1, 1, 6, 1, 0); tick();
    chk("d2_sel_a", sel_a, 0); chk("d2_sel_b", sel_b, 2);

    // same with $0 as destination
    set_id(1, 1, 2, 1, 1, 0, 1, 0); tick();
    set_id(1, 0, 0, 0, 0, 0, 0, 0); tick();
    set_id(1, 7, 0, 1, 1, 6, 1, 0); tick();
    chk("d2_zero_sel_b", sel_b, 0);

    // distance 3
    set_id(1, 1, 2, 1, 1, 3, 1, 0); tick();
    set_id(1, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
    set_id(1, 7, 3, 1, 1, 6, 1, 0); tick();
    chk("d3_sel_b", sel_b, 0);

    // load-use
    set_id(1, 1, 0, 1, 0, 8, 1, 1); tick();
    set_id(1, 8, 8, 1, 1, 9, 1, 0); #1 chk("lu_stall", stall, 1);
    tick();
    chk("lu_cnt", cnt, 1); chk("lu_bubble_sel_a", sel_a, 0);
    #1 chk("lu_stall_once", stall, 0);
    tick();
    chk("lu_sel_a", sel_a, 2); chk("lu_sel_b", sel_b, 2); chk("lu_cnt_after", cnt, 1);

    // load-use with flush in the same cycle
    set_id(1, 1, 0, 1, 0, 8, 1, 1); tick();
    set_id(1, 8, 8, 1, 1, 9, 1, 0); flush = 1'b1;
    #1 chk("flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    chk("flush_cnt", cnt, 1); chk("flush_sel_a", sel_a, 0); chk("flush_sel_b", sel_b, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();

    // halt with a pending EX/MEM forward
    set_id(1, 1, 2, 1, 1, 3, 1, 0); tick();
    chk("halt_pre_sel_a", sel_a, 0);
    set_id(1, 3, 5, 1, 1, 4, 1, 0); halt = 1'b1;
    repeat (5) tick();
    chk("halt_sel_a", sel_a, 0); chk("halt_cnt", cnt, 1);
    halt = 1'b0; tick();
    chk("halt_resume_sel_a", sel_a, 1);

    // halt while a load-use hazard is pending
    set_id(1, 1, 0, 1, 0, 8, 1, 1); tick();
    set_id(1, 8, 8, 1, 1, 9, 1, 0); halt = 1'b1;
    #1 chk("halt_lu_stall", stall, 1);
    repeat (3) tick();
    chk("halt_lu_cnt", cnt, 1);
    halt = 1'b0; tick();
    chk("halt_lu_cnt_rel", cnt, 2);
    tick();
    chk("halt_lu_sel_a", sel_a, 2); chk("halt_lu_sel_b", sel_b, 2);

    // lw $8,0($8) repeated: every other edge stalls
    set_id(1, 8, 0, 1, 0, 8, 1, 1);
    repeat (40) tick();
    chk("sat_cnt_main", cnt, 22); chk("sat_cnt_narrow", s_cnt, 15);
    set_id(0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
